// File: rtl/temp_seq_pkg.sv
// Shared types and helpers for the multi-channel temperature sequencer.
// Holds the state encoding, phase lengths and the enabled-channel search.
package temp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WINDOW,
        S_SETTLE,
        S_SAMPLE,
        S_STORE,
        S_DONE,
        S_WAIT
    } state_t;

    localparam int CLEAR_CYCLES  = 2;
    localparam int SETTLE_CYCLES = 2;
    localparam int MAX_CHANNELS  = 32;
    localparam int NO_CHANNEL    = MAX_CHANNELS;

    // Lowest enabled channel index at or above 'from'; NO_CHANNEL when none is left.
    function automatic int next_channel(input logic [MAX_CHANNELS-1:0] mask, input int from);
        int found;
        found = NO_CHANNEL;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) found = i;
        end
        return found;
    endfunction

endpackage

// File: rtl/temp_seq_if.sv
// Sensor-side bundle: oscillator power-up, counter clear and frozen counts.
interface temp_seq_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic [CHANNELS-1:0]       pwrupOsc;
    logic [CHANNELS-1:0]       resetCount;
    logic [CHANNELS*WIDTH-1:0] count;

    modport master (output pwrupOsc, output resetCount, input count);
    modport slave  (input pwrupOsc, input resetCount, output count);
endinterface

// File: rtl/temp_seq_acc.sv
// Accumulator, shift-average and threshold compare for the active channel.
module temp_seq_acc #(
    parameter int WIDTH        = 8,
    parameter int AVG_LOG2_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add_en,
    input  logic [WIDTH-1:0] sample,
    input  logic [2:0]       shift,
    input  logic [WIDTH-1:0] thr_high,
    input  logic [WIDTH-1:0] thr_low,
    output logic [WIDTH-1:0] avg,
    output logic             above,
    output logic             below
);
    localparam int ACC_W = WIDTH + AVG_LOG2_MAX;

    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + ACC_W'(sample);
        end
    end

    // Shift is clamped upstream, so the quotient always fits in WIDTH bits.
    assign avg   = WIDTH'(acc >> shift);
    assign above = avg > thr_high;
    assign below = avg < thr_low;
endmodule

// File: rtl/temp_seq.sv
// Multi-channel temperature sequencer: per-channel gated conversions, averaging,
// threshold alarms, one-shot or periodic sweeps.
//
//   state    | meaning
//   IDLE     | waiting for start
//   CLEAR    | counter held in clear, oscillator off
//   WINDOW   | oscillator of the active channel running
//   SETTLE   | oscillator stopped, count settling
//   SAMPLE   | count added to accumulator
//   STORE    | averaged result and alarms written
//   DONE     | one-cycle done pulse
//   WAIT     | idle gap between continuous sweeps
module temp_seq
    import temp_seq_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 4,
    parameter int AVG_LOG2_MAX = 3,
    parameter int WIN_WIDTH    = 8,
    parameter int PER_WIDTH    = 16
) (
    input  logic                      lfClk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [CHANNELS-1:0]       chEnable,
    input  logic [2:0]                avgLog2,
    input  logic [WIN_WIDTH-1:0]      winCycles,
    input  logic [PER_WIDTH-1:0]      periodCycles,
    input  logic [WIDTH-1:0]          thrHigh,
    input  logic [WIDTH-1:0]          thrLow,
    temp_seq_if.master                sens,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] result,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       alarmHigh,
    output logic [CHANNELS-1:0]       alarmLow,
    output logic [CHANNELS-1:0]       overflow
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CONV_W = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic [CHANNELS-1:0]     en_mask;
    logic [CHANNELS-1:0]     ch_onehot;
    logic [2:0]              avg_sh;
    logic [2:0]              avg_in;
    logic [WIN_WIDTH-1:0]    win_len;
    logic [WIN_WIDTH-1:0]    win_in;
    logic [WIN_WIDTH-1:0]    timer;
    logic [CONV_W-1:0]       conv_left;
    logic [CONV_W-1:0]       conv_in;
    logic [CONV_W-1:0]       conv_reload;
    logic [PER_WIDTH-1:0]    wait_cnt;
    logic [MAX_CHANNELS-1:0] req_ext;
    logic [MAX_CHANNELS-1:0] mask_ext;
    int                      first_ch;
    int                      next_ch;
    logic                    sweep_go;
    logic [WIDTH-1:0]        cur_count;
    logic [WIDTH-1:0]        avg_val;
    logic                    above;
    logic                    below;

    always_comb begin
        avg_in      = (int'(avgLog2) > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : avgLog2;
        win_in      = (winCycles == '0) ? WIN_WIDTH'(1) : winCycles;
        conv_in     = CONV_W'((1 << avg_in) - 1);
        conv_reload = CONV_W'((1 << avg_sh) - 1);
        req_ext     = '0;
        req_ext[CHANNELS-1:0] = chEnable;
        mask_ext    = '0;
        mask_ext[CHANNELS-1:0] = en_mask;
        first_ch    = next_channel(req_ext, 0);
        next_ch     = next_channel(mask_ext, int'(ch) + 1);
        ch_onehot   = CHANNELS'(1) << ch;
        cur_count   = sens.count[int'(ch)*WIDTH +: WIDTH];
        // The last WAIT cycle doubles as the start-sampling cycle of the next sweep.
        sweep_go    = ((state == S_IDLE) && start) ||
                      ((state == S_WAIT) && continuous && (wait_cnt <= PER_WIDTH'(1)));
    end

    temp_seq_acc #(
        .WIDTH        (WIDTH),
        .AVG_LOG2_MAX (AVG_LOG2_MAX)
    ) u_acc (
        .clk      (lfClk),
        .reset    (reset),
        .clear    (state == S_STORE),
        .add_en   (state == S_SAMPLE),
        .sample   (cur_count),
        .shift    (avg_sh),
        .thr_high (thrHigh),
        .thr_low  (thrLow),
        .avg      (avg_val),
        .above    (above),
        .below    (below)
    );

    always_ff @(posedge lfClk) begin
        if (reset) begin
            state           <= S_IDLE;
            ch              <= '0;
            en_mask         <= '0;
            avg_sh          <= '0;
            win_len         <= WIN_WIDTH'(1);
            timer           <= '0;
            conv_left       <= '0;
            wait_cnt        <= '0;
            sens.pwrupOsc   <= '0;
            sens.resetCount <= '1;
            busy            <= 1'b0;
            done            <= 1'b0;
            result          <= '0;
            valid           <= '0;
            alarmHigh       <= '0;
            alarmLow        <= '0;
            overflow        <= '0;
        end else begin
            done <= 1'b0;
            if (sweep_go) begin
                en_mask <= chEnable;
                avg_sh  <= avg_in;
                win_len <= win_in;
                busy    <= 1'b1;
                if (chEnable != '0) begin
                    alarmHigh <= '0;
                    alarmLow  <= '0;
                    overflow  <= '0;
                    ch        <= CH_W'(first_ch);
                    conv_left <= conv_in;
                    timer     <= WIN_WIDTH'(CLEAR_CYCLES - 1);
                    state     <= S_CLEAR;
                end else begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_CLEAR: begin
                        if (timer == '0) begin
                            state           <= S_WINDOW;
                            timer           <= win_len - WIN_WIDTH'(1);
                            sens.pwrupOsc   <= ch_onehot;
                            sens.resetCount <= ~ch_onehot;
                        end else begin
                            timer <= timer - WIN_WIDTH'(1);
                        end
                    end
                    S_WINDOW: begin
                        if (timer == '0) begin
                            state         <= S_SETTLE;
                            timer         <= WIN_WIDTH'(SETTLE_CYCLES - 1);
                            sens.pwrupOsc <= '0;
                        end else begin
                            timer <= timer - WIN_WIDTH'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (timer == '0) begin
                            state           <= S_SAMPLE;
                            sens.resetCount <= '1;
                        end else begin
                            timer <= timer - WIN_WIDTH'(1);
                        end
                    end
                    S_SAMPLE: begin
                        if (cur_count == '1) overflow[ch] <= 1'b1;
                        if (conv_left == '0) begin
                            state <= S_STORE;
                        end else begin
                            conv_left <= conv_left - CONV_W'(1);
                            timer     <= WIN_WIDTH'(CLEAR_CYCLES - 1);
                            state     <= S_CLEAR;
                        end
                    end
                    S_STORE: begin
                        result[int'(ch)*WIDTH +: WIDTH] <= avg_val;
                        valid[ch] <= 1'b1;
                        if (above) alarmHigh[ch] <= 1'b1;
                        if (below) alarmLow[ch]  <= 1'b1;
                        if (next_ch >= CHANNELS) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ch        <= CH_W'(next_ch);
                            conv_left <= conv_reload;
                            timer     <= WIN_WIDTH'(CLEAR_CYCLES - 1);
                            state     <= S_CLEAR;
                        end
                    end
                    S_DONE: begin
                        busy     <= 1'b0;
                        wait_cnt <= periodCycles;
                        state    <= continuous ? S_WAIT : S_IDLE;
                    end
                    S_WAIT: begin
                        if (!continuous) begin
                            state <= S_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt - PER_WIDTH'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_temp_seq.sv
// Self-checking bench for temp_seq: directed scenarios plus randomized sweeps
// checked against an arithmetic model of sweep timing, averaging and alarms.
module tb_temp_seq;
    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 4;
    localparam int WIN_WIDTH = 8;
    localparam int PER_WIDTH = 16;

    logic                      lfClk = 1'b0;
    logic                      reset;
    logic                      start;
    logic                      continuous;
    logic [CHANNELS-1:0]       chEnable;
    logic [2:0]                avgLog2;
    logic [WIN_WIDTH-1:0]      winCycles;
    logic [PER_WIDTH-1:0]      periodCycles;
    logic [WIDTH-1:0]          thrHigh;
    logic [WIDTH-1:0]          thrLow;
    logic                      busy;
    logic                      done;
    logic [CHANNELS*WIDTH-1:0] result;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       alarmHigh;
    logic [CHANNELS-1:0]       alarmLow;
    logic [CHANNELS-1:0]       overflow;

    temp_seq_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) sens ();

    temp_seq #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .AVG_LOG2_MAX(3),
        .WIN_WIDTH(WIN_WIDTH), .PER_WIDTH(PER_WIDTH)
    ) dut (
        .lfClk(lfClk), .reset(reset), .start(start), .continuous(continuous),
        .chEnable(chEnable), .avgLog2(avgLog2), .winCycles(winCycles),
        .periodCycles(periodCycles), .thrHigh(thrHigh), .thrLow(thrLow),
        .sens(sens), .busy(busy), .done(done), .result(result), .valid(valid),
        .alarmHigh(alarmHigh), .alarmLow(alarmLow), .overflow(overflow)
    );

    always #5 lfClk = ~lfClk;

    int vectors = 0;
    int miscompares = 0;

    // Sensor model: each power-up pulse delivers the next queued count for that channel.
    logic [WIDTH-1:0]    sq [CHANNELS][$];
    int                  pw_pulses [CHANNELS];
    logic [CHANNELS-1:0] pw_prev = '0;
    bit                  multi_hot = 1'b0;

    always @(negedge lfClk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (sens.pwrupOsc[c] && !pw_prev[c]) begin
                pw_pulses[c] = pw_pulses[c] + 1;
                if (sq[c].size() > 0) sens.count[c*WIDTH +: WIDTH] = sq[c].pop_front();
                else sens.count[c*WIDTH +: WIDTH] = '0;
            end
        end
        if ($countones(sens.pwrupOsc) > 1) multi_hot = 1'b1;
        pw_prev = sens.pwrupOsc;
    end

    logic [WIDTH-1:0]    exp_result [CHANNELS];
    logic [CHANNELS-1:0] exp_valid;

    function automatic logic [CHANNELS*WIDTH-1:0] pack_exp();
        logic [CHANNELS*WIDTH-1:0] p;
        for (int c = 0; c < CHANNELS; c++) p[c*WIDTH +: WIDTH] = exp_result[c];
        return p;
    endfunction

    function automatic int exp_latency(input logic [3:0] en, input int lg, input int w);
        int wn, a;
        wn = (w == 0) ? 1 : w;
        a  = 1 << ((lg > 3) ? 3 : lg);
        return $countones(en) * (a * (wn + 5) + 1) + 1;
    endfunction

    task automatic clear_q();
        for (int c = 0; c < CHANNELS; c++) sq[c].delete();
    endtask

    // Starts a sweep and reports the cycle of the done pulse (-1 on timeout)
    // and busy as seen in cycle 1; returns one cycle after done.
    task automatic run_sweep(input logic [3:0] en, input logic [2:0] lg, input logic [7:0] w,
                             output int lat, output logic b1);
        @(negedge lfClk);
        chEnable = en; avgLog2 = lg; winCycles = w; start = 1'b1;
        @(posedge lfClk);
        @(negedge lfClk);
        start = 1'b0;
        b1 = busy;
        lat = -1;
        for (int n = 1; n <= 3000; n++) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge lfClk);
            @(negedge lfClk);
        end
        if (lat > 0) begin
            @(posedge lfClk);
            @(negedge lfClk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; continuous = 1'b0; chEnable = '0; avgLog2 = '0;
        winCycles = '0; periodCycles = '0; thrHigh = '1; thrLow = '0;
        sens.count = '0;
        repeat (3) @(posedge lfClk);
        @(negedge lfClk);
        reset = 1'b0;
        @(posedge lfClk);
        @(negedge lfClk);
        for (int c = 0; c < CHANNELS; c++) exp_result[c] = '0;
        exp_valid = '0;
        vectors++; if (sens.pwrupOsc !== 4'h0) begin miscompares++; $display("FAIL rst_pwrup got %h want 0", sens.pwrupOsc); end
        vectors++; if (sens.resetCount !== 4'hF) begin miscompares++; $display("FAIL rst_resetCount got %h want f", sens.resetCount); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL rst_result got %h want 0", result); end
        vectors++; if (valid !== 4'h0) begin miscompares++; $display("FAIL rst_valid got %h want 0", valid); end
        vectors++; if ({alarmHigh, alarmLow} !== 8'h0) begin miscompares++; $display("FAIL rst_alarms got %h want 0", {alarmHigh, alarmLow}); end
        vectors++; if (overflow !== 4'h0) begin miscompares++; $display("FAIL rst_overflow got %h want 0", overflow); end
    endtask

    task automatic test_single();
        int lat; logic b1;
        clear_q();
        sq[0].push_back(8'd40);
        thrHigh = 8'd255; thrLow = 8'd0;
        run_sweep(4'b0001, 3'd0, 8'd4, lat, b1);
        exp_result[0] = 8'd40; exp_valid |= 4'b0001;
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL single_latency got %0d want 11", lat); end
        vectors++; if (b1 !== 1'b1) begin miscompares++; $display("FAIL single_busy_rise got %b want 1", b1); end
        vectors++; if (result[7:0] !== 8'd40) begin miscompares++; $display("FAIL single_result got %0d want 40", result[7:0]); end
        vectors++; if (valid !== 4'b0001) begin miscompares++; $display("FAIL single_valid got %b want 0001", valid); end
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_after_done got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_averaging();
        int lat; logic b1; int p0 [CHANNELS];
        clear_q();
        sq[0].push_back(8'd40); sq[0].push_back(8'd41); sq[0].push_back(8'd42); sq[0].push_back(8'd44);
        p0 = pw_pulses;
        run_sweep(4'b0001, 3'd2, 8'd3, lat, b1);
        exp_result[0] = 8'd41;
        vectors++; if (result[7:0] !== 8'd41) begin miscompares++; $display("FAIL avg_result got %0d want 41", result[7:0]); end
        vectors++; if (pw_pulses[0] - p0[0] !== 4) begin miscompares++; $display("FAIL avg_pulses got %0d want 4", pw_pulses[0] - p0[0]); end
        vectors++; if (lat !== 34) begin miscompares++; $display("FAIL avg_latency got %0d want 34", lat); end
    endtask

    task automatic test_multi_alarm();
        int lat; logic b1; int p0 [CHANNELS];
        clear_q();
        sq[1].push_back(8'd30); sq[3].push_back(8'd90);
        thrLow = 8'd35; thrHigh = 8'd80;
        p0 = pw_pulses;
        run_sweep(4'b1010, 3'd0, 8'd2, lat, b1);
        exp_result[1] = 8'd30; exp_result[3] = 8'd90; exp_valid |= 4'b1010;
        vectors++; if (alarmLow !== 4'b0010) begin miscompares++; $display("FAIL multi_alarmLow got %b want 0010", alarmLow); end
        vectors++; if (alarmHigh !== 4'b1000) begin miscompares++; $display("FAIL multi_alarmHigh got %b want 1000", alarmHigh); end
        vectors++; if ((pw_pulses[0] - p0[0]) + (pw_pulses[2] - p0[2]) !== 0) begin miscompares++; $display("FAIL multi_unpowered got %0d pulses want 0", (pw_pulses[0] - p0[0]) + (pw_pulses[2] - p0[2])); end
        vectors++; if (result !== pack_exp()) begin miscompares++; $display("FAIL multi_result got %h want %h", result, pack_exp()); end
        vectors++; if (valid !== exp_valid) begin miscompares++; $display("FAIL multi_valid got %b want %b", valid, exp_valid); end
        vectors++; if (lat !== 17) begin miscompares++; $display("FAIL multi_latency got %0d want 17", lat); end
    endtask

    task automatic test_threshold_equal();
        int lat; logic b1;
        clear_q();
        sq[0].push_back(8'd50);
        thrLow = 8'd50; thrHigh = 8'd50;
        run_sweep(4'b0001, 3'd0, 8'd1, lat, b1);
        exp_result[0] = 8'd50;
        vectors++; if ({alarmHigh, alarmLow} !== 8'h00) begin miscompares++; $display("FAIL equal_alarms got %h want 00", {alarmHigh, alarmLow}); end
        vectors++; if (result[7:0] !== 8'd50) begin miscompares++; $display("FAIL equal_result got %0d want 50", result[7:0]); end
    endtask

    task automatic test_overflow();
        int lat; logic b1;
        clear_q();
        sq[2].push_back(8'd255);
        thrLow = 8'd0; thrHigh = 8'd255;
        run_sweep(4'b0100, 3'd0, 8'd1, lat, b1);
        exp_result[2] = 8'd255; exp_valid |= 4'b0100;
        vectors++; if (overflow !== 4'b0100) begin miscompares++; $display("FAIL ovf_flag got %b want 0100", overflow); end
        vectors++; if (result[23:16] !== 8'd255) begin miscompares++; $display("FAIL ovf_result got %0d want 255", result[23:16]); end
        clear_q();
        sq[2].push_back(8'd10);
        run_sweep(4'b0100, 3'd0, 8'd1, lat, b1);
        exp_result[2] = 8'd10;
        vectors++; if (overflow !== 4'b0000) begin miscompares++; $display("FAIL ovf_cleared got %b want 0000", overflow); end
        vectors++; if (result[23:16] !== 8'd10) begin miscompares++; $display("FAIL ovf_result2 got %0d want 10", result[23:16]); end
    endtask

    task automatic test_zero_enable();
        int lat; logic b1;
        clear_q();
        run_sweep(4'b0000, 3'd0, 8'd4, lat, b1);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL zero_done got %0d want 1", lat); end
        vectors++; if (result !== pack_exp()) begin miscompares++; $display("FAIL zero_result got %h want %h", result, pack_exp()); end
        vectors++; if (valid !== exp_valid) begin miscompares++; $display("FAIL zero_valid got %b want %b", valid, exp_valid); end
    endtask

    task automatic test_random();
        int lat; logic b1; int p0 [CHANNELS];
        for (int it = 0; it < 20; it++) begin
            logic [3:0] en; int lg, lgn, w, a, sum, s;
            logic [3:0] e_hi, e_lo, e_of;
            en = 4'($urandom_range(1, 15));
            lg = $urandom_range(0, 5);
            w  = $urandom_range(0, 5);
            lgn = (lg > 3) ? 3 : lg;
            a = 1 << lgn;
            thrHigh = 8'($urandom_range(0, 255));
            thrLow  = 8'($urandom_range(0, 255));
            clear_q();
            e_hi = '0; e_lo = '0; e_of = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (en[c]) begin
                    sum = 0;
                    for (int k = 0; k < a; k++) begin
                        s = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
                        sq[c].push_back(8'(s));
                        sum += s;
                        if (s == 255) e_of[c] = 1'b1;
                    end
                    exp_result[c] = 8'(sum / a);
                    e_hi[c] = (exp_result[c] > thrHigh);
                    e_lo[c] = (exp_result[c] < thrLow);
                end
            end
            exp_valid |= en;
            p0 = pw_pulses;
            run_sweep(en, 3'(lg), 8'(w), lat, b1);
            vectors++; if (lat !== exp_latency(en, lg, w)) begin miscompares++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, exp_latency(en, lg, w)); end
            vectors++; if (result !== pack_exp()) begin miscompares++; $display("FAIL rand%0d_result got %h want %h", it, result, pack_exp()); end
            vectors++; if (valid !== exp_valid) begin miscompares++; $display("FAIL rand%0d_valid got %b want %b", it, valid, exp_valid); end
            vectors++; if (alarmHigh !== e_hi) begin miscompares++; $display("FAIL rand%0d_alarmHigh got %b want %b", it, alarmHigh, e_hi); end
            vectors++; if (alarmLow !== e_lo) begin miscompares++; $display("FAIL rand%0d_alarmLow got %b want %b", it, alarmLow, e_lo); end
            vectors++; if (overflow !== e_of) begin miscompares++; $display("FAIL rand%0d_overflow got %b want %b", it, overflow, e_of); end
            for (int c = 0; c < CHANNELS; c++) begin
                vectors++;
                if (pw_pulses[c] - p0[c] !== (en[c] ? a : 0)) begin
                    miscompares++;
                    $display("FAIL rand%0d_pulses_ch%0d got %0d want %0d", it, c, pw_pulses[c] - p0[c], en[c] ? a : 0);
                end
            end
        end
        vectors++; if (multi_hot !== 1'b0) begin miscompares++; $display("FAIL pwrup_onehot got %b want 0", multi_hot); end
    endtask

    task automatic test_continuous();
        int dt [3]; int k; int bad; int lat; logic b1;
        clear_q();
        for (int i = 0; i < 4; i++) sq[0].push_back(8'd20);
        thrLow = 8'd0; thrHigh = 8'd255;
        k = 0;
        @(negedge lfClk);
        continuous = 1'b1; periodCycles = 16'd10;
        chEnable = 4'b0001; avgLog2 = 3'd0; winCycles = 8'd2; start = 1'b1;
        @(posedge lfClk);
        @(negedge lfClk);
        start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            if (done === 1'b1) begin
                dt[k] = n;
                k++;
                if (k == 3) break;
            end
            @(posedge lfClk);
            @(negedge lfClk);
        end
        exp_result[0] = 8'd20; exp_valid |= 4'b0001;
        vectors++;
        if (k !== 3) begin
            miscompares++;
            $display("FAIL cont_pulses got %0d want 3", k);
        end else begin
            vectors++; if (dt[0] !== 9) begin miscompares++; $display("FAIL cont_first got %0d want 9", dt[0]); end
            vectors++; if (dt[1] - dt[0] !== 19) begin miscompares++; $display("FAIL cont_gap1 got %0d want 19", dt[1] - dt[0]); end
            vectors++; if (dt[2] - dt[1] !== 19) begin miscompares++; $display("FAIL cont_gap2 got %0d want 19", dt[2] - dt[1]); end
        end
        repeat (2) begin @(posedge lfClk); @(negedge lfClk); end
        continuous = 1'b0;
        bad = 0;
        repeat (30) begin
            @(posedge lfClk); @(negedge lfClk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL cont_stop got %0d active cycles want 0", bad); end
        clear_q();
        sq[0].push_back(8'd33);
        run_sweep(4'b0001, 3'd0, 8'd4, lat, b1);
        exp_result[0] = 8'd33;
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL cont_idle_restart got %0d want 11", lat); end
        vectors++; if (result !== pack_exp()) begin miscompares++; $display("FAIL cont_result got %h want %h", result, pack_exp()); end
    endtask

    task automatic test_reset_mid();
        int waited; int lat; logic b1;
        clear_q();
        sq[0].push_back(8'd77);
        @(negedge lfClk);
        chEnable = 4'b0001; avgLog2 = 3'd0; winCycles = 8'd8; start = 1'b1;
        @(posedge lfClk);
        @(negedge lfClk);
        start = 1'b0;
        waited = 0;
        while (sens.pwrupOsc[0] !== 1'b1 && waited < 20) begin
            @(posedge lfClk); @(negedge lfClk);
            waited++;
        end
        vectors++; if (sens.pwrupOsc[0] !== 1'b1) begin miscompares++; $display("FAIL mid_window_reached got %b want 1", sens.pwrupOsc[0]); end
        @(posedge lfClk); @(negedge lfClk);
        reset = 1'b1;
        @(posedge lfClk); @(negedge lfClk);
        vectors++; if (sens.pwrupOsc !== 4'h0) begin miscompares++; $display("FAIL mid_pwrup got %h want 0", sens.pwrupOsc); end
        vectors++; if (sens.resetCount !== 4'hF) begin miscompares++; $display("FAIL mid_resetCount got %h want f", sens.resetCount); end
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL mid_busy_done got %b want 00", {busy, done}); end
        vectors++; if (result !== 32'h0 || valid !== 4'h0) begin miscompares++; $display("FAIL mid_result got %h/%b want 0/0", result, valid); end
        vectors++; if ({alarmHigh, alarmLow, overflow} !== 12'h0) begin miscompares++; $display("FAIL mid_flags got %h want 0", {alarmHigh, alarmLow, overflow}); end
        reset = 1'b0;
        for (int c = 0; c < CHANNELS; c++) exp_result[c] = '0;
        exp_valid = '0;
        clear_q();
        sq[0].push_back(8'd12);
        thrLow = 8'd0; thrHigh = 8'd255;
        run_sweep(4'b0001, 3'd0, 8'd4, lat, b1);
        vectors++; if (lat !== 11 || result !== 32'd12) begin miscompares++; $display("FAIL mid_restart got lat=%0d result=%h want 11/0000000c", lat, result); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_averaging();
        test_multi_alarm();
        test_threshold_equal();
        test_overflow();
        test_zero_enable();
        test_random();
        test_continuous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
